// File: rtl/hazard_ctrl_p.sv
// Pipeline stall/flush controller: load-latency scoreboard, HI/LO busy tracking,
// multi-cycle trap flush sequencer and a saturating hazard-stall counter.
module hazard_ctrl_p #(
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int AW           = 5,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pause,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs_addr,
  input  logic             id_rs_en,
  input  logic [AW-1:0]    id_rt_addr,
  input  logic             id_rt_en,
  input  logic             id_memtoreg,
  input  logic [AW-1:0]    id_regdst_addr,
  input  logic             id_mc_start,
  input  logic             id_uses_hilo,
  input  logic             mc_done,
  input  logic             id_is_branch,
  input  logic             id_bpu_wen_h,
  input  logic             id_syscall,
  input  logic             id_eret,
  input  logic             cp0_interrupt_i,
  input  logic             cp0_exception_tlb_i,
  input  logic             cp0_exception_tlb_byinstr_i,
  output logic             pa_pc_ifid_o,
  output logic             pa_idexmemwr_o,
  output logic             wash_ifid_o,
  output logic             wash_idex_o,
  output logic             wash_exmem_o,
  output logic             wash_memwr_o,
  output logic             flush_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_e;

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [LOAD_LAT-1:0]         sb_v_q, sb_v_d;
  logic [LOAD_LAT-1:0][AW-1:0] sb_a_q, sb_a_d;
  logic                        mc_busy_q, mc_busy_d;
  state_e                      state_q, state_d;
  logic [FW-1:0]               fcnt_q, fcnt_d;
  logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;

  logic load_hit, hazard, trap, dtlb, in_flush, issue, wash_ifid, wash_idex;

  // Entries never hold r0, so a read of r0 can never match.
  always_comb begin
    load_hit = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (sb_v_q[i] && ((id_rs_en && sb_a_q[i] == id_rs_addr) ||
                        (id_rt_en && sb_a_q[i] == id_rt_addr))) begin
        load_hit = 1'b1;
      end
    end
    load_hit = load_hit & id_valid;
  end

  assign hazard   = load_hit | (id_valid & id_uses_hilo & mc_busy_q);
  assign dtlb     = cp0_exception_tlb_i & ~cp0_exception_tlb_byinstr_i;
  assign trap     = (id_valid & (id_syscall | id_eret)) | cp0_exception_tlb_i | cp0_interrupt_i;
  assign in_flush = (state_q == S_FLUSH);

  always_comb begin
    wash_ifid = 1'b0;
    if (!pause && !hazard) begin
      wash_ifid = in_flush | trap | (id_is_branch & id_bpu_wen_h);
    end
  end

  assign wash_idex = ~pause & (hazard | dtlb | in_flush);
  assign issue     = id_valid & ~pause & ~hazard & ~wash_idex;

  assign pa_pc_ifid_o   = rst_n & (pause | hazard);
  assign pa_idexmemwr_o = rst_n & pause;
  assign wash_ifid_o    = rst_n & wash_ifid;
  assign wash_idex_o    = rst_n & wash_idex;
  assign wash_exmem_o   = rst_n & ~pause & dtlb;
  assign wash_memwr_o   = rst_n & ~pause & dtlb;
  assign flush_busy_o   = rst_n & in_flush;
  assign stall_cnt_o    = rst_n ? stall_cnt_q : '0;

  always_comb begin
    sb_v_d      = sb_v_q;
    sb_a_d      = sb_a_q;
    mc_busy_d   = mc_busy_q;
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    stall_cnt_d = stall_cnt_q;

    if (!pause) begin
      for (int i = LOAD_LAT - 1; i > 0; i--) begin
        sb_v_d[i] = sb_v_q[i-1];
        sb_a_d[i] = sb_a_q[i-1];
      end
      sb_v_d[0] = issue & id_memtoreg & (id_regdst_addr != '0);
      sb_a_d[0] = id_regdst_addr;
    end

    // A new mul/div issuing in the same cycle the old one finishes keeps busy set.
    if (issue && id_mc_start) begin
      mc_busy_d = 1'b1;
    end else if (mc_done) begin
      mc_busy_d = 1'b0;
    end

    case (state_q)
      S_RUN: begin
        if (FLUSH_CYCLES > 1 && !pause && !hazard && trap) begin
          state_d = S_FLUSH;
          fcnt_d  = FW'(FLUSH_CYCLES - 1);
        end
      end
      S_FLUSH: begin
        if (!pause) begin
          if (fcnt_q == FW'(1)) begin
            state_d = S_RUN;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q - FW'(1);
          end
        end
      end
      default: begin
        state_d = S_RUN;
        fcnt_d  = '0;
      end
    endcase

    if (!pause && hazard && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_v_q      <= '0;
      sb_a_q      <= '0;
      mc_busy_q   <= 1'b0;
      state_q     <= S_RUN;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_v_q      <= sb_v_d;
      sb_a_q      <= sb_a_d;
      mc_busy_q   <= mc_busy_d;
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
